// File: rtl/led_pkg.sv
// Shared types and widths for the LED frame scheduler.
package led_pkg;
  localparam int PIX_W     = 24;
  localparam int BIT_CNT_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    SHIFT,
    GAP
  } state_t;
endpackage

// File: rtl/led_pix_serializer.sv
// 24-bit GRB load/shift register with its transfer counter; MSB leaves first.
module led_pix_serializer
  import led_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [PIX_W-1:0]     din,
  input  logic                 shift,
  output logic                 msb,
  output logic [BIT_CNT_W-1:0] cnt
);
  logic [PIX_W-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= din;
      cnt <= '0;
    end else if (shift) begin
      sr  <= {sr[PIX_W-2:0], 1'b0};
      cnt <= cnt + 1'b1;
    end
  end

  assign msb = sr[PIX_W-1];
endmodule

// File: rtl/led_frame_sched.sv
// Frame scheduler: fetches NUM_LEDS pixels, serialises each one under
// encoder backpressure, then holds a latch gap before pulsing frame_done.
module led_frame_sched
  import led_pkg::*;
#(
  parameter  int NUM_LEDS   = 8,
  parameter  int GAP_CYCLES = 4000,
  localparam int AW         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_busy,
  output logic [AW-1:0]    o_pix_addr,
  output logic             o_pix_rd,
  input  logic [PIX_W-1:0] i_pix_data,
  output logic             o_bit_valid,
  output logic             o_bit,
  input  logic             i_bit_ready,
  output logic             o_frame_done
);
  state_t               state;
  logic [15:0]          gap_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 msb;
  logic                 xfer;
  logic                 last_bit;

  assign xfer     = o_bit_valid & i_bit_ready;
  assign last_bit = xfer && (bit_cnt == BIT_CNT_W'(PIX_W-1));
  assign o_bit    = o_bit_valid & msb;

  // read data lands the cycle after o_pix_rd, i.e. while in WAIT_DATA
  led_pix_serializer u_ser (
    .clk   (i_clk),
    .rst   (i_rst),
    .load  (state == WAIT_DATA),
    .din   (i_pix_data),
    .shift (xfer),
    .msb   (msb),
    .cnt   (bit_cnt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      o_busy       <= 1'b0;
      o_pix_rd     <= 1'b0;
      o_bit_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      o_pix_addr   <= '0;
      gap_cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          o_pix_addr <= '0;
          o_busy     <= 1'b1;
          o_pix_rd   <= 1'b1;
          state      <= FETCH;
        end
        FETCH: begin
          o_pix_rd <= 1'b0;
          state    <= WAIT_DATA;
        end
        WAIT_DATA: begin
          o_bit_valid <= 1'b1;
          state       <= SHIFT;
        end
        SHIFT: if (last_bit) begin
          o_bit_valid <= 1'b0;
          if (o_pix_addr < AW'(NUM_LEDS-1)) begin
            o_pix_addr <= o_pix_addr + 1'b1;
            o_pix_rd   <= 1'b1;
            state      <= FETCH;
          end else begin
            // counts down to 0; done is raised for the cycle spent at 0
            gap_cnt      <= 16'(GAP_CYCLES-1);
            o_frame_done <= (GAP_CYCLES == 1);
            state        <= GAP;
          end
        end
        GAP: if (gap_cnt == 16'd0) begin
          o_frame_done <= 1'b0;
          o_busy       <= 1'b0;
          state        <= IDLE;
        end else begin
          gap_cnt      <= gap_cnt - 16'd1;
          o_frame_done <= (gap_cnt == 16'd1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_frame_sched.sv
// Scoreboard bench: stimulus queues expected bits, negedge monitors pop and compare.
module tb_led_frame_sched;
  logic        clk = 1'b0;
  logic        rst, start, ready;
  logic [23:0] pix_data = '0;
  logic        busy, pix_rd, bit_valid, sbit, frame_done;
  logic [0:0]  pix_addr;

  logic        start_b, ready_b;
  logic [23:0] pix_data_b = '0;
  logic        busy_b, pix_rd_b, bit_valid_b, sbit_b, frame_done_b;
  logic [0:0]  pix_addr_b;

  logic [23:0] mem [2];
  logic [23:0] mem_b;
  bit          exp_q[$];
  bit          exp_qb[$];

  int tests = 0, fails = 0;
  int xfers = 0, busy_cyc = 0, done_cnt = 0, rd_cnt = 0;
  int done_b_cnt = 0, cyc = 0, last_done_b = -1;
  bit hold_pend = 0, hold_bit = 0, rd_prev = 0;

  always #5 clk = ~clk;

  led_frame_sched #(.NUM_LEDS(2), .GAP_CYCLES(10)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy),
    .o_pix_addr(pix_addr), .o_pix_rd(pix_rd), .i_pix_data(pix_data),
    .o_bit_valid(bit_valid), .o_bit(sbit), .i_bit_ready(ready),
    .o_frame_done(frame_done));

  led_frame_sched #(.NUM_LEDS(1), .GAP_CYCLES(3)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .o_busy(busy_b),
    .o_pix_addr(pix_addr_b), .o_pix_rd(pix_rd_b), .i_pix_data(pix_data_b),
    .o_bit_valid(bit_valid_b), .o_bit(sbit_b), .i_bit_ready(ready_b),
    .o_frame_done(frame_done_b));

  // pixel buffers with one-cycle read latency
  always @(posedge clk) begin
    if (pix_rd)   pix_data   <= mem[pix_addr];
    if (pix_rd_b) pix_data_b <= mem_b;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // monitor for the two-pixel instance
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 0;
      rd_cnt    = 0;
      rd_prev   = 0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", bit_valid, 1);
        chk("hold_bit", sbit, hold_bit);
      end
      hold_pend = 0;
      if (bit_valid && ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_bit: got bit %0d with nothing expected", sbit);
        end else chk("bit", sbit, exp_q.pop_front());
        xfers++;
      end else if (bit_valid) begin
        hold_pend = 1;
        hold_bit  = sbit;
      end
      if (pix_rd) begin
        chk("rd_no_valid", bit_valid, 0);
        chk("rd_busy", busy, 1);
        chk("rd_single", rd_prev, 0);
        chk("rd_addr", pix_addr, rd_cnt % 2);
        rd_cnt++;
      end
      rd_prev = pix_rd;
      if (busy) busy_cyc++;
      if (frame_done) done_cnt++;
    end
  end

  // monitor for the single-pixel instance (ready tied high)
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bit_valid_b) begin
        if (exp_qb.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_extra_bit: got bit %0d with nothing expected", sbit_b);
        end else chk("b_bit", sbit_b, exp_qb.pop_front());
      end
      if (pix_rd_b) chk("b_addr", pix_addr_b, 0);
      if (frame_done_b) begin
        if (last_done_b >= 0) chk("b_period", cyc - last_done_b, 30);
        last_done_b = cyc;
        done_b_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_pix(input logic [23:0] p);
    for (int i = 23; i >= 0; i--) exp_q.push_back(p[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (busy && n < limit) begin tick(); n++; end
    chk(name, busy, 0);
  endtask

  initial begin
    #400000;
    fails++;
    $display("FAIL timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    int n, exp_done;
    rst = 1; start = 0; ready = 0; start_b = 0; ready_b = 1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_pix_rd", pix_rd, 0);
    chk("rst_valid", bit_valid, 0);
    chk("rst_bit", sbit, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_addr", pix_addr, 0);
    start = 1; tick();
    rst = 0; start = 0; tick();
    chk("start_in_rst", busy, 0);

    // basic frame, ready always high
    mem[0] = 24'hFF0000; mem[1] = 24'h00AA55;
    push_pix(mem[0]); push_pix(mem[1]);
    ready = 1; busy_cyc = 0; done_cnt = 0; xfers = 0;
    pulse_start();
    wait_idle(200, "t1_idle");
    chk("t1_busy_cycles", busy_cyc, 62);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_xfers", xfers, 48);
    chk("t1_q_empty", exp_q.size(), 0);

    // ready toggling
    mem[0] = 24'h123456; mem[1] = 24'hABCDEF;
    push_pix(mem[0]); push_pix(mem[1]);
    done_cnt = 0; xfers = 0;
    pulse_start();
    n = 0;
    while (busy && n < 400) begin ready = ~ready; tick(); n++; end
    ready = 1;
    chk("t2_idle", busy, 0);
    chk("t2_xfers", xfers, 48);
    chk("t2_done_pulses", done_cnt, 1);
    chk("t2_q_empty", exp_q.size(), 0);

    // start pulses during SHIFT and GAP are ignored
    mem[0] = 24'h0F0F0F; mem[1] = 24'hF0F0F0;
    push_pix(mem[0]); push_pix(mem[1]);
    done_cnt = 0;
    pulse_start();
    repeat (8) tick();
    chk("t3_in_shift", bit_valid, 1);
    pulse_start();
    repeat (46) tick();
    chk("t3_gap_busy", busy, 1);
    chk("t3_gap_valid", bit_valid, 0);
    pulse_start();
    wait_idle(100, "t3_idle");
    repeat (5) tick();
    chk("t3_stays_idle", busy, 0);
    chk("t3_done_pulses", done_cnt, 1);
    chk("t3_q_empty", exp_q.size(), 0);

    // reset after the 10th transfer of pixel 1, then replay
    mem[0] = 24'h800001; mem[1] = 24'h7FFFFE;
    push_pix(mem[0]); push_pix(mem[1]);
    done_cnt = 0; xfers = 0;
    pulse_start();
    n = 0;
    while (xfers < 10 && n < 100) begin @(negedge clk); #1; n++; end
    chk("t4_reach10", xfers, 10);
    @(posedge clk); #1;
    rst = 1; tick();
    chk("t4_busy", busy, 0);
    chk("t4_valid", bit_valid, 0);
    chk("t4_bit", sbit, 0);
    chk("t4_pix_rd", pix_rd, 0);
    chk("t4_done", frame_done, 0);
    chk("t4_addr", pix_addr, 0);
    rst = 0;
    exp_q.delete();
    chk("t4_no_done", done_cnt, 0);
    push_pix(mem[0]); push_pix(mem[1]);
    xfers = 0;
    pulse_start();
    wait_idle(200, "t4_idle");
    chk("t4_xfers", xfers, 48);
    chk("t4_done_pulses", done_cnt, 1);
    chk("t4_q_empty", exp_q.size(), 0);

    // single-pixel instance, start held high for two frames
    mem_b = 24'hC3A50F;
    for (int f = 0; f < 2; f++)
      for (int i = 23; i >= 0; i--) exp_qb.push_back(mem_b[i]);
    done_b_cnt = 0; last_done_b = -1;
    start_b = 1;
    n = 0;
    while (done_b_cnt < 2 && n < 200) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    start_b = 0;
    repeat (40) tick();
    chk("t5_idle", busy_b, 0);
    chk("t5_done_pulses", done_b_cnt, 2);
    chk("t5_q_empty", exp_qb.size(), 0);

    // random ready/start with one reset abort
    exp_done = done_cnt;
    for (int f = 0; f < 4; f++) begin
      int abort_at;
      abort_at = $urandom_range(5, 60);
      mem[0] = $urandom; mem[1] = $urandom;
      push_pix(mem[0]); push_pix(mem[1]);
      pulse_start();
      n = 0;
      while (busy && n < 600) begin
        if (f == 1 && n == abort_at) begin
          start = 0; rst = 1; tick(); rst = 0;
          exp_q.delete();
          break;
        end
        ready = 1'($urandom_range(0, 1));
        start = ($urandom_range(0, 9) == 0);
        tick(); n++;
      end
      start = 0; ready = 1;
      if (f != 1) exp_done++;
      chk("t6_idle", busy, 0);
      chk("t6_q_empty", exp_q.size(), 0);
    end
    repeat (3) tick();
    chk("t6_done_pulses", done_cnt, exp_done);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
